mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: WORD_SIZE, default `WORD_SIZE (16), width of addresses and data.
REQ-002 Parameter: STARVE_LIMIT, default 4, the most consecutive data grants allowed while a fetch waits.
REQ-003 Ports:
 clk  in  1  clock; all state changes on the rising edge.
 reset  in  1  asynchronous, active-high reset.
 i_req  in  1  instruction-fetch request, level; held until i_done.
 i_addr  in  WORD_SIZE  fetch address.
 i_done  out  1  one-cycle pulse; fetch complete, i_rdata valid.
 i_rdata  out  WORD_SIZE  fetched word, held until next fetch completes.
 i_stall  out  1  i_req && !i_done (combinational).
 d_req  in  1  data-access request, level; held until d_done.
 d_we  in  1  1 = store, 0 = load.
 d_addr  in  WORD_SIZE  data address.
 d_wdata  in  WORD_SIZE  store data.
 d_done  out  1  one-cycle pulse; access complete, d_rdata valid on loads.
 d_rdata  out  WORD_SIZE  loaded word, held until next load completes.
 d_stall  out  1  d_req && !d_done (combinational).
 mem_read  out  1  memory read strobe.
 mem_write  out  1  memory write strobe.
 mem_addr  out  WORD_SIZE  memory address.
 mem_wdata  out  WORD_SIZE  memory write data.
 mem_rdata  in  WORD_SIZE  memory read data, valid when mem_ready.
 mem_ready  in  1  memory completes the current access this cycle.
 busy  out  1  state != IDLE.

Function
REQ-004 FSM states are IDLE, I_BUSY and D_BUSY, and all FSM outputs are registered.
REQ-005 In IDLE, when d_req=1 and not (i_req=1 and starve_cnt==STARVE_LIMIT), the next state shall be D_BUSY.
REQ-006 Otherwise in IDLE, when i_req=1, the next state shall be I_BUSY; when neither request is high, the FSM stays in IDLE.
REQ-007 On a grant edge, mem_addr and mem_wdata shall latch from the winner's inputs.
REQ-008 On a data grant, mem_read=!d_we and mem_write=d_we; on a fetch grant, mem_read=1 and mem_write=0.
REQ-009 mem_addr, mem_wdata, mem_read and mem_write shall stay stable for the whole busy state, even if requester inputs change.
REQ-010 Grants are non-preemptive: a busy state ends only on mem_ready=1.
REQ-011 On mem_ready in I_BUSY: i_rdata<=mem_rdata, i_done=1 next cycle, strobes cleared, state becomes IDLE.
REQ-012 On mem_ready in D_BUSY: d_rdata<=mem_rdata if it is a load (d_rdata unchanged on a store), d_done=1 next cycle, strobes cleared, state becomes IDLE.
REQ-013 The cycle in which done is high is spent in IDLE and arbitrates normally; requesters deassert req that cycle unless they issue a new request.
REQ-014 A req still high in the done cycle counts as a new request.
REQ-015 mem_ready in IDLE shall be ignored.
REQ-016 Minimum latency from req in IDLE to done is 2 cycles (grant edge, then mem_ready in the first busy cycle).
REQ-017 Peak throughput is one access per (memory latency + 1) cycles.
REQ-018 starve_cnt: width clog2(STARVE_LIMIT+1).
REQ-019 starve_cnt shall increment on each data grant with i_req=1, saturating at STARVE_LIMIT.
REQ-020 starve_cnt shall clear on each fetch grant and on each data grant with i_req=0.
REQ-021 When i_req and d_req are both high in IDLE with starve_cnt<STARVE_LIMIT, data wins.
REQ-022 When i_req and d_req are both high in IDLE with starve_cnt==STARVE_LIMIT, fetch wins.
REQ-023 i_done and d_done shall never be high in the same cycle.
REQ-024 mem_read and mem_write shall never be high together.

Reset
REQ-025 While reset=1, asynchronously: state=IDLE, starve_cnt=0.
REQ-026 While reset=1: mem_read, mem_write, i_done, d_done and busy = 0.
REQ-027 While reset=1: mem_addr, mem_wdata, i_rdata and d_rdata = 0.
REQ-028 Reset during I_BUSY or D_BUSY shall abandon the access with no done pulse and no rdata update.
REQ-029 The first grant after reset release shall occur on the first rising edge with reset=0 and a request high.

Verification
REQ-030 Fetch only: i_req=1, i_addr=16'h0010, mem_ready one cycle after grant with mem_rdata=16'hA5A5 -> mem_read=1, mem_addr=16'h0010 for 1 cycle; i_done pulse; i_rdata=16'hA5A5.
REQ-031 Store: d_req=1, d_we=1, d_addr=16'h0100, d_wdata=16'h1234, mem_ready after 3 busy cycles -> mem_write=1 for 3 cycles; d_done pulse; d_rdata unchanged.
REQ-032 Simultaneous requests with starve_cnt=0 -> D_BUSY first; fetch granted only after d_done, if d_req=0 then.
REQ-033 d_req continuously high, i_req high, STARVE_LIMIT=4 -> exactly 4 data accesses, then a fetch grant, then starve_cnt=0.
REQ-034 Reset asserted mid-D_BUSY, d_addr changed during busy -> all outputs 0 immediately, no d_done; mem_addr never followed a mid-busy change.
REQ-035 Random mem_ready latency 1-8 with random requests -> mem_read/mem_write never both high; i_done/d_done never coincide; every req eventually done.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between an instruction-fetch requester and a data requester.
// Data normally wins; a starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_port_arbiter #(
  parameter int WORD_SIZE    = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic                 i_done,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_stall,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_done,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_stall,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ready,
  output logic                 busy
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

  state_t                 state_q;
  logic [SW-1:0]          starve_q;
  logic [SW-1:0]          starve_d;
  logic                   data_win;
  logic                   mem_read_q;
  logic                   mem_write_q;
  logic [WORD_SIZE-1:0]   mem_addr_q;
  logic [WORD_SIZE-1:0]   mem_wdata_q;
  logic                   i_done_q;
  logic                   d_done_q;
  logic [WORD_SIZE-1:0]   i_rdata_q;
  logic [WORD_SIZE-1:0]   d_rdata_q;

  // Data wins unless a waiting fetch has already been passed over STARVE_LIMIT times.
  always_comb begin
    data_win = d_req && !(i_req && (starve_q == LIMIT));
    starve_d = '0;
    if (i_req) begin
      starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (data_win) begin
            state_q     <= D_BUSY;
            starve_q    <= starve_d;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
            mem_read_q  <= !d_we;
            mem_write_q <= d_we;
          end else if (i_req) begin
            state_q     <= I_BUSY;
            starve_q    <= '0;
            mem_addr_q  <= i_addr;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b1;
            mem_write_q <= 1'b0;
          end
        end
        I_BUSY: begin
          if (mem_ready) begin
            state_q     <= IDLE;
            i_rdata_q   <= mem_rdata;
            i_done_q    <= 1'b1;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
          end
        end
        D_BUSY: begin
          if (mem_ready) begin
            state_q <= IDLE;
            // The write strobe still encodes load vs store for the access in flight.
            if (!mem_write_q) begin
              d_rdata_q <= mem_rdata;
            end
            d_done_q    <= 1'b1;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_stall   = i_req && !i_done_q;
  assign d_stall   = d_req && !d_done_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester tasks push expectations, a monitor pops and compares.
module tb_mem_port_arbiter;
  localparam int W = 16;
  localparam logic [W-1:0] K = 16'hA5B5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [W-1:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [W-1:0] mem_rdata = '0;
  logic mem_ready = 1'b0;
  logic i_done, d_done, i_stall, d_stall, mem_read, mem_write, busy;
  logic [W-1:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  mem_port_arbiter #(.WORD_SIZE(W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    int           len;
  } grant_t;

  grant_t       exp_g[$];
  logic [W-1:0] exp_i[$];
  logic [W-1:0] exp_d[$];
  int n_cmp = 0;
  int n_err = 0;
  int lat_v = 1;
  bit rand_lat = 0;
  bit check_grants = 1;
  bit stray = 0;
  int rsp_cnt = 0;
  int rsp_lat = 1;
  bit act = 0;
  int run = 0;
  grant_t cur;
  logic [W-1:0] d_model = '0;
  logic [W-1:0] burst_exp [5] = '{16'hB5B5, 16'hB5B4, 16'hB5B7, 16'hB5B6, 16'hB5B1};

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act_v, exp_v);
    end
  endtask

  task automatic push_g(input logic rd, input logic wr, input logic [W-1:0] a,
                        input logic [W-1:0] wd, input int len);
    grant_t g;
    g.rd = rd; g.wr = wr; g.addr = a; g.wdata = wd; g.len = len;
    exp_g.push_back(g);
  endtask

  task automatic wait_done(input bit port_i, input int exp_cyc, input string name);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(port_i ? i_done : d_done) && c < 200);
    if (!(port_i ? i_done : d_done)) chk({name, "_timeout"}, 0, 1);
    else if (exp_cyc != 0) chk({name, "_latency"}, c, exp_cyc);
  endtask

  task automatic fetch(input logic [W-1:0] a, input logic [W-1:0] e, input int cyc);
    exp_i.push_back(e);
    i_addr = a;
    i_req = 1'b1;
    wait_done(1'b1, cyc, "fetch");
    i_req = 1'b0;
  endtask

  task automatic data(input logic we, input logic [W-1:0] a, input logic [W-1:0] wd,
                      input logic [W-1:0] e, input int cyc);
    exp_d.push_back(e);
    d_we = we;
    d_addr = a;
    d_wdata = wd;
    d_req = 1'b1;
    wait_done(1'b0, cyc, "data");
    d_req = 1'b0;
  endtask

  // Memory model: read data is address ^ K, presented only in the ready cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (reset || !(mem_read || mem_write)) begin
        rsp_cnt = 0;
        mem_ready = stray && !reset;
        mem_rdata = 16'hDEAD;
      end else begin
        if (rsp_cnt == 0) rsp_lat = rand_lat ? int'($urandom_range(1, 8)) : lat_v;
        rsp_cnt++;
        mem_ready = (rsp_cnt == rsp_lat);
        mem_rdata = mem_ready ? (mem_addr ^ K) : 16'hDEAD;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        act = 0;
      end else begin
        chk("rd_wr_exclusive", {31'd0, mem_read && mem_write}, 0);
        chk("done_exclusive", {31'd0, i_done && d_done}, 0);
        chk("i_stall", {31'd0, i_stall}, {31'd0, i_req && !i_done});
        chk("d_stall", {31'd0, d_stall}, {31'd0, d_req && !d_done});
        chk("busy", {31'd0, busy}, {31'd0, mem_read || mem_write});
        if ((mem_read || mem_write) && !act) begin
          act = 1;
          run = 1;
          if (check_grants && exp_g.size() != 0) begin
            cur = exp_g.pop_front();
            chk("grant_rd", {31'd0, mem_read}, {31'd0, cur.rd});
            chk("grant_wr", {31'd0, mem_write}, {31'd0, cur.wr});
            chk("grant_addr", mem_addr, cur.addr);
            if (cur.wr) chk("grant_wdata", mem_wdata, cur.wdata);
          end else begin
            if (check_grants) chk("grant_unexpected", 1, 0);
            cur.rd = mem_read; cur.wr = mem_write; cur.addr = mem_addr;
            cur.wdata = mem_wdata; cur.len = 0;
          end
        end else if ((mem_read || mem_write) && act) begin
          run++;
          chk("addr_stable", mem_addr, cur.addr);
          chk("rd_stable", {31'd0, mem_read}, {31'd0, cur.rd});
          if (cur.wr) chk("wdata_stable", mem_wdata, cur.wdata);
        end else if (act) begin
          act = 0;
          if (cur.len != 0) chk("busy_len", run, cur.len);
        end
        if (i_done) begin
          if (exp_i.size() == 0) chk("i_done_unexpected", 1, 0);
          else chk("i_rdata", i_rdata, exp_i.pop_front());
        end
        if (d_done) begin
          if (exp_d.size() == 0) chk("d_done_unexpected", 1, 0);
          else chk("d_rdata", d_rdata, exp_d.pop_front());
        end
      end
    end
  end

  initial begin
    logic [W-1:0] ra, rw, re;
    logic rwe;
    repeat (2) @(negedge clk);
    chk("rst_mem_read", {31'd0, mem_read}, 0);
    chk("rst_mem_write", {31'd0, mem_write}, 0);
    chk("rst_i_done", {31'd0, i_done}, 0);
    chk("rst_d_done", {31'd0, d_done}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);

    // Fetch already requested at reset release: grant on the first edge, done two cycles later.
    lat_v = 1;
    push_g(1'b1, 1'b0, 16'h0010, 16'h0000, 1);
    exp_i.push_back(16'hA5A5);
    i_addr = 16'h0010;
    i_req = 1'b1;
    reset = 1'b0;
    wait_done(1'b1, 2, "first_fetch");
    i_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("i_rdata_hold", i_rdata, 16'hA5A5);

    lat_v = 2;
    push_g(1'b1, 1'b0, 16'h0200, 16'h0000, 2);
    data(1'b0, 16'h0200, 16'h0000, 16'hA7B5, 3);

    lat_v = 3;
    push_g(1'b0, 1'b1, 16'h0100, 16'h1234, 3);
    data(1'b1, 16'h0100, 16'h1234, 16'hA7B5, 4);

    stray = 1;
    repeat (3) @(negedge clk);
    stray = 0;
    @(negedge clk);
    chk("idle_ready_d_rdata", d_rdata, 16'hA7B5);
    chk("idle_ready_i_rdata", i_rdata, 16'hA5A5);

    // Simultaneous requests: data first, fetch after d_done.
    lat_v = 1;
    push_g(1'b1, 1'b0, 16'h0300, 16'h0000, 1);
    push_g(1'b1, 1'b0, 16'h0040, 16'h0000, 1);
    fork
      data(1'b0, 16'h0300, 16'h0000, 16'hA6B5, 2);
      fetch(16'h0040, 16'hA5F5, 4);
    join

    // Continuous data requests: four data grants, then the starved fetch, then data again.
    for (int k = 0; k < 4; k++) push_g(1'b1, 1'b0, 16'h1000 + 16'(k), 16'h0000, 1);
    push_g(1'b1, 1'b0, 16'h0080, 16'h0000, 1);
    push_g(1'b1, 1'b0, 16'h1004, 16'h0000, 1);
    fork
      begin
        d_we = 1'b0;
        d_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
          d_addr = 16'h1000 + 16'(k);
          exp_d.push_back(burst_exp[k]);
          wait_done(1'b0, 0, "burst");
        end
        d_req = 1'b0;
      end
      fetch(16'h0080, 16'hA535, 0);
    join

    push_g(1'b1, 1'b0, 16'h0500, 16'h0000, 1);
    push_g(1'b1, 1'b0, 16'h0050, 16'h0000, 1);
    fork
      data(1'b0, 16'h0500, 16'h0000, 16'hA0B5, 2);
      fetch(16'h0050, 16'hA5E5, 4);
    join

    // Reset in the middle of a long load whose address input moves during the access.
    lat_v = 8;
    push_g(1'b1, 1'b0, 16'h0600, 16'h0000, 0);
    d_we = 1'b0;
    d_addr = 16'h0600;
    d_req = 1'b1;
    repeat (3) @(negedge clk);
    d_addr = 16'h0BAD;
    @(negedge clk);
    chk("mid_busy_addr", mem_addr, 16'h0600);
    #2 reset = 1'b1;
    #1;
    chk("arst_mem_read", {31'd0, mem_read}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_d_done", {31'd0, d_done}, 0);
    chk("arst_d_rdata", d_rdata, 0);
    chk("arst_i_rdata", i_rdata, 0);
    d_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 0);

    // Random traffic with random memory latency.
    check_grants = 0;
    rand_lat = 1;
    d_model = '0;
    fork
      for (int n = 0; n < 12; n++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        ra = 16'($urandom);
        fetch(ra, ra ^ K, 0);
      end
      for (int n = 0; n < 12; n++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        rwe = 1'($urandom_range(0, 1));
        rw = 16'($urandom);
        re = 16'($urandom);
        if (!rwe) d_model = re ^ K;
        data(rwe, re, rw, d_model, 0);
      end
    join

    repeat (3) @(negedge clk);
    chk("exp_i_left", exp_i.size(), 0);
    chk("exp_d_left", exp_d.size(), 0);
    chk("exp_g_left", exp_g.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
